// File: rtl/shumezuesi_sekuencial.sv
// rtl/shumezuesi_sekuencial.sv - time-shared 16-bit adder sequencer for ADD and shift-and-add MUL
// Holds the ripple-carry adder and the START/BUSY/DONE sequencer that is its sole driver.

module Mbledhesi16bit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic carry;

    always_comb begin
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end
endmodule

module shumezuesi_sekuencial #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               OP,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] RESULT
);
    typedef enum logic [1:0] {S_IDLE, S_ADD, S_MUL, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   add_a, add_b, add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] shifted;

    // Operand steering: MUL accumulates into P_HI, adding M only when the current multiplier bit is set.
    always_comb begin
        add_a = m_q;
        add_b = p_lo_q;
        if (state_q == S_MUL) begin
            add_a = p_hi_q;
            add_b = p_lo_q[0] ? m_q : '0;
        end
    end

    Mbledhesi16bit #(.WIDTH(WIDTH)) u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (1'b0),
        .sum_o (add_sum),
        .cout_o(add_cout)
    );

    assign shifted = {add_cout, add_sum, p_lo_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    m_d     = A;
                    p_lo_d  = B;
                    p_hi_d  = '0;
                    cnt_d   = '0;
                    state_d = OP ? S_MUL : S_ADD;
                end
            end
            S_ADD: begin
                result_d = {{(WIDTH-1){1'b0}}, add_cout, add_sum};
                state_d  = S_FIN;
            end
            S_MUL: begin
                {p_hi_d, p_lo_d} = shifted;
                cnt_d            = cnt_q + CNT_W'(1);
                // The counter wraps on this same edge, so termination keys off the pre-increment value.
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    result_d = shifted;
                    state_d  = S_FIN;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
endmodule

// File: tb/tb_shumezuesi_sekuencial.sv
// tb/tb_shumezuesi_sekuencial.sv - scoreboard bench for the ADD/MUL sequencer
module tb_shumezuesi_sekuencial;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        OP = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    shumezuesi_sekuencial dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .OP    (OP),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    // Reference model: command acceptance, latency and result from plain arithmetic.
    logic [31:0] sb_res  [0:511];
    int          sb_edge [0:511];
    int          wr_ptr = 0;
    int          cyc = 0;
    int          next_accept = 0;
    int          busy_lo = 0;
    int          busy_hi = -1;
    int          lat;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            next_accept = 0;
            busy_hi     = -1;
        end else begin
            cyc = cyc + 1;
            if (START && cyc >= next_accept) begin
                lat = OP ? 16 : 1;
                sb_res[wr_ptr]  = OP ? (32'(A) * 32'(B)) : (32'(A) + 32'(B));
                sb_edge[wr_ptr] = cyc + lat;
                wr_ptr      = wr_ptr + 1;
                busy_lo     = cyc;
                busy_hi     = cyc + lat;
                next_accept = cyc + lat + 2;
            end
        end
    end

    // Monitor: owns the read pointer and all comparison counters.
    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_ptr = 0;
    logic [31:0] held = '0;
    logic        exp_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            #1;
            chk("reset_busy", 32'(BUSY), 32'd0);
            chk("reset_done", 32'(DONE), 32'd0);
            chk("reset_result", RESULT, 32'd0);
            rd_ptr = wr_ptr;
            held   = '0;
        end else begin
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            chk("busy", 32'(BUSY), 32'(exp_busy));
            if (rd_ptr < wr_ptr) begin
                if (DONE) begin
                    chk("done_cycle", 32'(cyc), 32'(sb_edge[rd_ptr]));
                    chk("result", RESULT, sb_res[rd_ptr]);
                    held   = sb_res[rd_ptr];
                    rd_ptr = rd_ptr + 1;
                end else if (cyc > sb_edge[rd_ptr]) begin
                    chk("done_missing", 32'(DONE), 32'd1);
                    rd_ptr = rd_ptr + 1;
                end
            end else if (DONE) begin
                chk("spurious_done", 32'(DONE), 32'd0);
            end
            if (!DONE) chk("result_hold", RESULT, held);
        end
    end

    task automatic pulse(input logic op, input logic [15:0] a, input logic [15:0] b);
        START = 1'b1;
        OP    = op;
        A     = a;
        B     = b;
        @(negedge CLK);
        START = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2 RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        pulse(1'b1, 16'd10, 16'd9);
        repeat (20) @(negedge CLK);

        pulse(1'b0, 16'hFFFF, 16'h0001);
        repeat (3) @(negedge CLK);
        pulse(1'b0, 16'd20, 16'd9);
        repeat (3) @(negedge CLK);

        pulse(1'b1, 16'hFFFF, 16'hFFFF);
        repeat (18) @(negedge CLK);
        pulse(1'b1, 16'h1234, 16'h0000);
        repeat (18) @(negedge CLK);

        pulse(1'b1, 16'd15, 16'd9);
        repeat (4) @(negedge CLK);
        pulse(1'b0, 16'd1, 16'd1);
        repeat (11) @(negedge CLK);
        pulse(1'b0, 16'd1, 16'd1);
        pulse(1'b0, 16'd2, 16'd3);
        repeat (4) @(negedge CLK);

        pulse(1'b1, 16'h00FF, 16'h0100);
        repeat (7) @(negedge CLK);
        #2 RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        pulse(1'b1, 16'h00FF, 16'h0100);
        repeat (18) @(negedge CLK);

        START = 1'b1;
        OP    = 1'b0;
        A     = 16'd3;
        B     = 16'd4;
        repeat (15) @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);

        for (int i = 0; i < 80; i++) begin
            START = ($urandom_range(0, 2) == 0);
            OP    = 1'($urandom_range(0, 1));
            A     = pick();
            B     = pick();
            @(negedge CLK);
        end
        START = 1'b0;
        repeat (25) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shumezuesi_sekuencial.md
Name: shumezuesi_sekuencial

Overview:
Multi-cycle arithmetic sequencer that time-shares one 16-bit ripple-carry adder instance (Mbledhesi16bit) between two operations: a single-pass ADD and an unsigned 16x16->32 shift-and-add MULTIPLY. It accepts one operation at a time through a START/BUSY/DONE handshake. It holds the 32-bit result until the next accepted command. It sits between the CPU control unit and the adder datapath as the adder's sole driver.

Parameters:
WIDTH, 16, operand width; must equal the adder instance width; only 16 is supported and verified
CNT_W, 4, iteration counter width, log2(WIDTH)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  asynchronous, active-high; clears all state and outputs immediately
START  input  1  command strobe, sampled on rising edge only while in IDLE
OP  input  1  operation select, sampled with START: 0 = ADD, 1 = MUL
A  input  16  operand A, ADD augend / MUL multiplicand, latched on accepted START
B  input  16  operand B, ADD addend / MUL multiplier, latched on accepted START
BUSY  output  1  high in every non-IDLE state
DONE  output  1  one-cycle pulse, result valid
RESULT  output  32  ADD: {15'b0, COUT, SUM}; MUL: full 32-bit product

Behaviour:
- Reset, asynchronous: state=IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, internal M/P_HI/P_LO=0. Reset asserted mid-operation aborts it with no DONE pulse. The first START after reset deasserts is accepted normally.
- States: IDLE, ADD, MUL, FIN. BUSY=1 in ADD, MUL and FIN. DONE=1 only in FIN. Both outputs are registered state decodes.
- IDLE: START=1 at an edge latches M<=A and P_LO<=B, clears P_HI<=0 and counter<=0. Next state is ADD if OP=0, MUL if OP=1. START=0 keeps the block in IDLE.
- The single adder instance has inputs selected by state. In ADD its operands are M and P_LO. In MUL they are P_HI and (P_LO[0] ? M : 16'h0000).
- ADD: one cycle. RESULT<={15'b0,COUT,SUM}, then go to FIN. Latency: START edge n -> DONE high in the cycle after edge n+1.
- MUL: one iteration per edge, 16 iterations total. Each iteration does {P_HI,P_LO}<={COUT,SUM,P_LO[15:1]} and counter<=counter+1. On the iteration where counter==15 (the 16th), load RESULT with the shifted {P_HI,P_LO} value and go to FIN. Latency: START edge n -> DONE high in the cycle after edge n+16.
- FIN: lasts one cycle, then unconditionally returns to IDLE. A START present during FIN is ignored. A new command is accepted at the earliest in the first IDLE cycle.
- START while BUSY=1 is ignored, with no queuing. A and B changing during an operation have no effect.
- RESULT changes only on the completion edge (entry to FIN). It holds its value through IDLE and through the next operation until that operation completes.
- Counter wrap: the 4-bit counter wraps 15->0 on the final iteration. Termination is decided by counter==15, never by wrap detection.
- Product is unsigned and exact. Max 0xFFFF*0xFFFF=0xFFFE0001, which fits in 32 bits. The adder COUT is captured into P_HI's MSB on every iteration and is never lost.
- The block contains no combinational path from inputs to outputs.

Test Plan:
- Reset, then START OP=1 A=10 B=9 -> BUSY high the next cycle; DONE pulses exactly 17 cycles after the START edge; RESULT=0x0000005A.
- START OP=0 A=0xFFFF B=0x0001 -> DONE 2 cycles after START; RESULT=0x00010000 (carry captured). Then OP=0 A=20 B=9 -> RESULT=0x0000001D.
- START OP=1 A=0xFFFF B=0xFFFF -> RESULT=0xFFFE0001. Follow with OP=1 A=0x1234 B=0 -> RESULT=0x00000000, still 17-cycle latency.
- START OP=1 A=15 B=9, with START re-pulsed (OP=0 A=1 B=1) at cycles 5 and 17 -> both re-pulses ignored; single DONE; RESULT=0x00000087; next IDLE START is accepted.
- START OP=1 A=0x00FF B=0x0100, RESET pulsed asynchronously (between clock edges) at cycle 8 -> BUSY, DONE and RESULT go to 0 immediately; no DONE pulse follows. A fresh START with the same operands yields RESULT=0x0000FF00.
- Hold START=1 continuously with OP=0 A=3 B=4 -> a new operation is accepted every 3 cycles (IDLE, ADD, FIN); each DONE carries RESULT=0x00000007.
